// File: rtl/cdb_arbiter_if.sv
// Result-bus interface between the functional-unit requesters, the CDB arbiter
// and the commit stage. The arbiter uses the slave view; the requester/commit side uses master.
interface cdb_arbiter_if #(
  parameter int NREQ = 3
);
  // Commit-stage redirect
  logic                 flush_i;

  // Requester side
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [5*NREQ-1:0]    req_regaddr_i;
  logic [5*NREQ-1:0]    req_id_i;
  logic [32*NREQ-1:0]   req_data_i;
  logic [32*NREQ-1:0]   req_pc_i;
  logic [2*NREQ-1:0]    req_branch_tag_i;
  logic [NREQ-1:0]      req_cond_i;

  // Registered output stage towards commit
  logic                 en_o;
  logic [4:0]           regaddr_o;
  logic [4:0]           id_o;
  logic [31:0]          data_o;
  logic [31:0]          pc_o;
  logic [1:0]           branch_tag_o;
  logic                 cond_o;
  logic [1:0]           grant_idx_o;

  modport master (
    output flush_i, req_valid_i, req_regaddr_i, req_id_i, req_data_i,
           req_pc_i, req_branch_tag_i, req_cond_i,
    input  req_ready_o, en_o, regaddr_o, id_o, data_o, pc_o,
           branch_tag_o, cond_o, grant_idx_o
  );

  modport slave (
    input  flush_i, req_valid_i, req_regaddr_i, req_id_i, req_data_i,
           req_pc_i, req_branch_tag_i, req_cond_i,
    output req_ready_o, en_o, regaddr_o, id_o, data_o, pc_o,
           branch_tag_o, cond_o, grant_idx_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin result-bus arbiter with branch priority and a starvation guard,
// feeding a one-entry registered output stage into the commit stage.
module cdb_arbiter #(
  parameter int NREQ     = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef logic [IW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic [4:0]  regaddr;
    logic [4:0]  id;
    logic [31:0] data;
    logic [31:0] pc;
    logic [1:0]  branch_tag;
    logic        cond;
  } result_t;

  idx_t       ptr_q, ptr_d;
  cnt_t       wait_q [NREQ];
  cnt_t       wait_d [NREQ];
  result_t    out_q, out_d;
  logic       en_q, en_d;
  logic [1:0] grant_idx_q, grant_idx_d;

  idx_t            rot_idx [NREQ];
  logic [NREQ-1:0] is_branch;
  logic            starve_hit, branch_hit, any_hit;
  idx_t            starve_idx, branch_idx, any_idx;
  logic            grant_valid, grant_fire;
  idx_t            grant_idx;

  // (p + k) mod NREQ without a divider; p < NREQ and k < NREQ.
  function automatic idx_t rot(input idx_t p, input int k);
    logic [IW:0] s;
    s = {1'b0, p} + (IW+1)'(k);
    if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
    return s[IW-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      rot_idx[k]   = rot(ptr_q, k);
      is_branch[k] = |bus.req_branch_tag_i[2*k +: 2];
    end
  end

  // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    branch_hit = 1'b0;
    branch_idx = '0;
    any_hit    = 1'b0;
    any_idx    = '0;
    // Descending scans: the last hit written is the lowest index / nearest to ptr.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid_i[i] && (wait_q[i] == cnt_t'(MAX_WAIT))) begin
        starve_hit = 1'b1;
        starve_idx = idx_t'(i);
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid_i[rot_idx[k]] && is_branch[rot_idx[k]]) begin
        branch_hit = 1'b1;
        branch_idx = rot_idx[k];
      end
      if (bus.req_valid_i[rot_idx[k]]) begin
        any_hit = 1'b1;
        any_idx = rot_idx[k];
      end
    end
  end

  always_comb begin
    grant_valid = starve_hit | branch_hit | any_hit;
    if (starve_hit)      grant_idx = starve_idx;
    else if (branch_hit) grant_idx = branch_idx;
    else                 grant_idx = any_idx;
    // Reset and redirect both suppress any transfer in the current cycle.
    grant_fire = grant_valid && !rst && !bus.flush_i;
  end

  assign bus.req_ready_o = grant_fire ? (NREQ'(1) << grant_idx) : '0;

  always_comb begin
    en_d        = grant_fire;
    out_d       = '0;
    grant_idx_d = '0;
    ptr_d       = ptr_q;
    if (grant_fire) begin
      out_d.regaddr    = bus.req_regaddr_i[5*int'(grant_idx) +: 5];
      out_d.id         = bus.req_id_i[5*int'(grant_idx) +: 5];
      out_d.data       = bus.req_data_i[32*int'(grant_idx) +: 32];
      out_d.pc         = bus.req_pc_i[32*int'(grant_idx) +: 32];
      out_d.branch_tag = bus.req_branch_tag_i[2*int'(grant_idx) +: 2];
      out_d.cond       = bus.req_cond_i[grant_idx];
      grant_idx_d      = 2'(grant_idx);
      ptr_d            = (grant_idx == idx_t'(NREQ - 1)) ? '0 : grant_idx + idx_t'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      if (bus.flush_i || !bus.req_valid_i[i] || (grant_fire && (grant_idx == idx_t'(i))))
        wait_d[i] = '0;
      else if (wait_q[i] < cnt_t'(MAX_WAIT))
        wait_d[i] = wait_q[i] + cnt_t'(1);
      else
        wait_d[i] = wait_q[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      out_q       <= '0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      for (int i = 0; i < NREQ; i++) wait_q[i] <= '0;
    end else begin
      en_q        <= en_d;
      out_q       <= out_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      for (int i = 0; i < NREQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign bus.en_o         = en_q;
  assign bus.regaddr_o    = out_q.regaddr;
  assign bus.id_o         = out_q.id;
  assign bus.data_o       = out_q.data;
  assign bus.pc_o         = out_q.pc;
  assign bus.branch_tag_o = out_q.branch_tag;
  assign bus.cond_o       = out_q.cond;
  assign bus.grant_idx_o  = grant_idx_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grant, round-robin, branch
// priority, starvation guard, flush and reset-with-flush.
module tb_cdb_arbiter;
  localparam int NREQ     = 3;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NREQ(NREQ)) bus ();

  cdb_arbiter #(.NREQ(NREQ), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0]  m_reg  [NREQ];
  logic [4:0]  m_id   [NREQ];
  logic [31:0] m_data [NREQ];
  logic [31:0] m_pc   [NREQ];
  logic [1:0]  m_tag  [NREQ];
  logic        m_cond [NREQ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] ra, input logic [4:0] id,
                         input logic [31:0] d, input logic [31:0] pc,
                         input logic [1:0] tg, input logic c);
    m_reg[i] = ra; m_id[i] = id; m_data[i] = d; m_pc[i] = pc; m_tag[i] = tg; m_cond[i] = c;
    bus.req_regaddr_i[5*i +: 5]     = ra;
    bus.req_id_i[5*i +: 5]          = id;
    bus.req_data_i[32*i +: 32]      = d;
    bus.req_pc_i[32*i +: 32]        = pc;
    bus.req_branch_tag_i[2*i +: 2]  = tg;
    bus.req_cond_i[i]               = c;
  endtask

  task automatic load_all(input logic [1:0] t0, input logic [1:0] t1, input logic [1:0] t2);
    set_req(0, 5'd10, 5'd20, 32'hA000_0000, 32'h0000_1000, t0, 1'b0);
    set_req(1, 5'd11, 5'd21, 32'hA000_0001, 32'h0000_1004, t1, 1'b1);
    set_req(2, 5'd12, 5'd22, 32'hA000_0002, 32'h0000_1008, t2, 1'b0);
  endtask

  // One arbitration cycle: comb grant checked mid-cycle, output stage checked after the edge.
  task automatic step(input string tag, input logic [NREQ-1:0] exp_ready,
                      input logic exp_en, input int w);
    @(negedge clk);
    check({tag, ".ready"}, 32'(bus.req_ready_o), 32'(exp_ready));
    @(posedge clk);
    #1;
    check({tag, ".en"}, 32'(bus.en_o), 32'(exp_en));
    if (exp_en) begin
      check({tag, ".gidx"},    32'(bus.grant_idx_o),  32'(w));
      check({tag, ".regaddr"}, 32'(bus.regaddr_o),    32'(m_reg[w]));
      check({tag, ".id"},      32'(bus.id_o),         32'(m_id[w]));
      check({tag, ".data"},    bus.data_o,            m_data[w]);
      check({tag, ".pc"},      bus.pc_o,              m_pc[w]);
      check({tag, ".btag"},    32'(bus.branch_tag_o), 32'(m_tag[w]));
      check({tag, ".cond"},    32'(bus.cond_o),       32'(m_cond[w]));
    end else begin
      check({tag, ".gidx0"},    32'(bus.grant_idx_o),  32'h0);
      check({tag, ".payload0"}, {bus.regaddr_o, bus.id_o, bus.branch_tag_o, bus.cond_o} , 32'h0);
      check({tag, ".data0"},    bus.data_o,            32'h0);
      check({tag, ".pc0"},      bus.pc_o,              32'h0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.flush_i = 1'b0;
    step("rst", '0, 1'b0, 0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.flush_i          = 1'b0;
    bus.req_valid_i      = '0;
    bus.req_regaddr_i    = '0;
    bus.req_id_i         = '0;
    bus.req_data_i       = '0;
    bus.req_pc_i         = '0;
    bus.req_branch_tag_i = '0;
    bus.req_cond_i       = '0;

    // Reset held two cycles with every requester valid.
    load_all(2'b00, 2'b00, 2'b00);
    bus.req_valid_i = 3'b111;
    rst = 1'b1;
    step("reset0", 3'b000, 1'b0, 0);
    step("reset1", 3'b000, 1'b0, 0);
    check("reset.ptr", 32'(dut.ptr_q), 32'd0);
    for (int i = 0; i < NREQ; i++) check("reset.wait", 32'(dut.wait_q[i]), 32'd0);

    // Single request from requester 1.
    rst = 1'b0;
    bus.req_valid_i = 3'b000;
    set_req(1, 5'd5, 5'd3, 32'hDEAD_BEEF, 32'h0000_0400, 2'b00, 1'b0);
    bus.req_valid_i = 3'b010;
    step("single", 3'b010, 1'b1, 1);
    bus.req_valid_i = 3'b000;
    step("idle", 3'b000, 1'b0, 0);
    check("single.ptr", 32'(dut.ptr_q), 32'd2);

    // Round-robin with all valid and no branches.
    do_reset();
    load_all(2'b00, 2'b00, 2'b00);
    bus.req_valid_i = 3'b111;
    step("rr0", 3'b001, 1'b1, 0);
    step("rr1", 3'b010, 1'b1, 1);
    step("rr2", 3'b100, 1'b1, 2);
    step("rr3", 3'b001, 1'b1, 0);
    step("rr4", 3'b010, 1'b1, 1);

    // Branch priority from ptr=0: req2 (tag 01) beats req0 (tag 00).
    do_reset();
    load_all(2'b00, 2'b00, 2'b01);
    bus.req_valid_i = 3'b101;
    step("br0", 3'b100, 1'b1, 2);
    bus.req_valid_i = 3'b001;
    step("br1", 3'b001, 1'b1, 0);
    bus.req_valid_i = 3'b000;
    step("br_idle", 3'b000, 1'b0, 0);

    // Starvation guard: two branch requesters keep winning until req2 hits MAX_WAIT.
    do_reset();
    load_all(2'b01, 2'b01, 2'b00);
    bus.req_valid_i = 3'b111;
    step("st1", 3'b001, 1'b1, 0);
    step("st2", 3'b010, 1'b1, 1);
    step("st3", 3'b001, 1'b1, 0);
    step("st4", 3'b010, 1'b1, 1);
    check("st4.wait2", 32'(dut.wait_q[2]), 32'(MAX_WAIT));
    step("st5", 3'b100, 1'b1, 2);
    check("st5.wait2", 32'(dut.wait_q[2]), 32'd0);
    check("st5.wait0", 32'(dut.wait_q[0]), 32'd2);
    check("st5.ptr",   32'(dut.ptr_q),     32'd0);
    step("st6", 3'b001, 1'b1, 0);

    // Flush kills the grant, clears counters and keeps ptr.
    do_reset();
    load_all(2'b00, 2'b00, 2'b00);
    bus.req_valid_i = 3'b111;
    step("fl_pre", 3'b001, 1'b1, 0);
    check("fl_pre.wait1", 32'(dut.wait_q[1]), 32'd1);
    bus.flush_i = 1'b1;
    step("fl", 3'b000, 1'b0, 0);
    bus.flush_i = 1'b0;
    for (int i = 0; i < NREQ; i++) check("fl.wait", 32'(dut.wait_q[i]), 32'd0);
    check("fl.ptr", 32'(dut.ptr_q), 32'd1);
    step("fl_resume", 3'b010, 1'b1, 1);

    // Reset and flush together: reset wins, ptr returns to 0.
    rst = 1'b1;
    bus.flush_i = 1'b1;
    step("rstfl", 3'b000, 1'b0, 0);
    check("rstfl.ptr", 32'(dut.ptr_q), 32'd0);
    rst = 1'b0;
    bus.flush_i = 1'b0;
    step("rstfl_post", 3'b001, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
